periph_uart_tx: RTL and testbench

PERIPH_UART_TX -- requirements
Module: periph_uart_tx

---
 rtl/periph_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_periph_uart_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/periph_uart_tx.sv
// Memory-mapped UART transmitter: a sequence-byte change in the output peripheral window
// queues the data byte into a 1-deep buffer, then an 8N1 serialiser sends it LSB first.
module periph_uart_tx #(
  parameter int unsigned OUTPUT_PERIPH_LEN = 'h20,
  parameter int unsigned TX_DATA_OFFSET    = 'h0,
  parameter int unsigned TX_SEQ_OFFSET     = 'h1,
  parameter int unsigned CLKS_PER_BIT      = 434
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [OUTPUT_PERIPH_LEN-1:0][7:0] output_peripherals_mem_i,
  output logic                              tx_o,
  output logic                              busy_o,
  output logic [7:0]                        status_o
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             overrun_q, overrun_d;
  logic             primed_q;
  logic [7:0]       last_seq_q;
  logic             tx_q, tx_d;

  logic [7:0] seq_byte;
  logic [7:0] data_byte;
  logic       req;
  logic       buf_take;
  logic       baud_end;

  assign seq_byte  = output_peripherals_mem_i[TX_SEQ_OFFSET];
  assign data_byte = output_peripherals_mem_i[TX_DATA_OFFSET];

  // The first edge after reset only primes last_seq, so a stale sequence byte is never an event.
  assign req      = primed_q && (seq_byte != last_seq_q);
  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    buf_take = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (buf_full_q) begin
          buf_take = 1'b1;
          shift_d  = buf_q;
          baud_d   = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          idx_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // A buffered byte chains straight into the next start bit with no idle gap.
          if (buf_full_q) begin
            buf_take = 1'b1;
            shift_d  = buf_q;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    overrun_d  = overrun_q;
    if (buf_take) begin
      buf_full_d = 1'b0;
    end
    if (req) begin
      if (!buf_full_q || buf_take) begin
        buf_d      = data_byte;
        buf_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // tx is registered, so its level is derived from the state being entered.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      buf_q      <= 8'h00;
      buf_full_q <= 1'b0;
      overrun_q  <= 1'b0;
      primed_q   <= 1'b0;
      last_seq_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      overrun_q  <= overrun_d;
      primed_q   <= 1'b1;
      last_seq_q <= seq_byte;
      tx_q       <= tx_d;
    end
  end

  assign tx_o     = tx_q;
  assign busy_o   = (state_q != StIdle) || buf_full_q;
  assign status_o = {5'b0, overrun_q, buf_full_q, busy_o};

endmodule

// File: tb/tb_periph_uart_tx.sv
// Directed bench for periph_uart_tx: a bit-level receiver decodes tx and checks each frame
// against a queue of bytes expected from the sequence writes.
module tb_periph_uart_tx;

  localparam int unsigned Cpb = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0][7:0] mem = '0;
  logic             tx;
  logic             busy;
  logic [7:0]       status;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];

  periph_uart_tx #(
    .OUTPUT_PERIPH_LEN ('h20),
    .TX_DATA_OFFSET    ('h0),
    .TX_SEQ_OFFSET     ('h1),
    .CLKS_PER_BIT      (Cpb)
  ) dut (
    .clk_i                    (clk),
    .rst_ni                   (rst_n),
    .output_peripherals_mem_i (mem),
    .tx_o                     (tx),
    .busy_o                   (busy),
    .status_o                 (status)
  );

  always #5 clk = ~clk;

  // Receiver: one sample per cycle on the falling edge, 40 samples per frame.
  logic [39:0] rx_samp;
  int          rx_n = 0;
  bit          rx_active = 0;
  int          sample_n = 0;
  int          last_end = -100;
  int          frame_gap = -1;
  int          frames_seen = 0;
  logic        rx_ok;
  logic [7:0]  rx_byte;
  logic [7:0]  rx_exp;

  always @(negedge clk) begin
    sample_n++;
    if (!rst_n) begin
      rx_active = 0;
    end else if (rx_active || tx === 1'b0) begin
      if (!rx_active) begin
        rx_active = 1;
        rx_n      = 0;
        frame_gap = sample_n - last_end - 1;
      end
      rx_samp[rx_n] = tx;
      rx_n++;
      if (rx_n == 40) begin
        rx_active = 0;
        last_end  = sample_n;
        frames_seen++;
        rx_ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
          for (int j = 1; j < 4; j++) begin
            if (rx_samp[4*k+j] !== rx_samp[4*k]) rx_ok = 1'b0;
          end
        end
        if (rx_samp[0] !== 1'b0 || rx_samp[36] !== 1'b1) rx_ok = 1'b0;
        for (int k = 0; k < 8; k++) rx_byte[k] = rx_samp[4+4*k];
        tests++;
        assert (rx_ok === 1'b1) else begin
          fails++;
          $error("FAIL frame_shape: observed samples %b, required 4-cycle bits with start 0 stop 1",
                 rx_samp);
        end
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $error("FAIL unexpected_frame: observed byte %h, required no frame", rx_byte);
        end else begin
          rx_exp = exp_q.pop_front();
          assert (rx_byte === rx_exp) else begin
            fails++;
            $error("FAIL frame_data: observed %h, required %h", rx_byte, rx_exp);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] seq, input logic [7:0] data);
    @(negedge clk);
    mem[0] = data;
    mem[1] = seq;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    repeat (2) @(negedge clk);
    while (busy === 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (busy === 1'b0) else begin
      fails++;
      $error("FAIL wait_idle: observed busy %b after %0d cycles, required 0", busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish within time limit");
    $fatal(1, "timeout");
  end

  int f0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_status", 32'(status), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // First frame: capture edge then start edge
    f0 = frames_seen;
    send(8'h01, 8'hA5);
    exp_q.push_back(8'hA5);
    @(posedge clk);
    #1;
    check("capture_status", 32'(status), 32'h03);
    check("capture_tx", 32'(tx), 32'd1);
    @(posedge clk);
    #1;
    check("start_tx", 32'(tx), 32'd0);
    check("start_status", 32'(status), 32'h01);
    wait_idle(100);
    check("frame1_count", frames_seen - f0, 1);
    check("frame1_drained", exp_q.size(), 0);

    // Buffered second byte chains back-to-back; third byte overruns
    f0 = frames_seen;
    send(8'h02, 8'hA5);
    exp_q.push_back(8'hA5);
    repeat (6) @(negedge clk);
    send(8'h03, 8'h3C);
    exp_q.push_back(8'h3C);
    @(posedge clk);
    #1;
    check("buffered_status", 32'(status), 32'h03);
    send(8'h04, 8'h5A);
    @(posedge clk);
    #1;
    check("overrun_status", 32'(status), 32'h07);
    wait_idle(200);
    check("chain_count", frames_seen - f0, 2);
    check("chain_gap", frame_gap, 0);
    check("chain_drained", exp_q.size(), 0);
    check("overrun_sticky", 32'(status), 32'h04);

    // Reset during data bit 3 aborts the frame at once
    f0 = frames_seen;
    send(8'h05, 8'hA5);
    exp_q.push_back(8'hA5);
    repeat (19) @(posedge clk);
    #1;
    check("bit3_tx", 32'(tx), 32'd0);
    check("bit3_status", 32'(status), 32'h05);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_status", 32'(status), 32'h00);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_frame", frames_seen - f0, 0);
    check("abort_busy", 32'(busy), 32'd0);

    // Nonzero sequence byte held across reset is not an event
    f0 = frames_seen;
    rst_n = 1'b0;
    mem[0] = 8'h33;
    mem[1] = 8'h07;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("held_seq_no_frame", frames_seen - f0, 0);
    check("held_seq_status", 32'(status), 32'h00);
    send(8'h08, 8'hC3);
    exp_q.push_back(8'hC3);
    wait_idle(100);
    check("seq08_count", frames_seen - f0, 1);

    // Sequence wrap FF -> 00 with an all-zero byte
    f0 = frames_seen;
    send(8'hFF, 8'h81);
    exp_q.push_back(8'h81);
    wait_idle(100);
    send(8'h00, 8'h00);
    exp_q.push_back(8'h00);
    wait_idle(100);
    check("wrap_count", frames_seen - f0, 2);
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_status", 32'(status), 32'h00);
    check("final_tx", 32'(tx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
